// File: rtl/dmem_arbiter_if.sv
// Bundle of the core (C), debug/DMA (D) and data-memory (M) signals around dmem_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface dmem_arbiter_if;
    logic        c_req;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [1:0]  c_we;
    logic [2:0]  c_re;
    logic        c_gnt;
    logic [31:0] c_rdata;
    logic        c_rvalid;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_we;
    logic [2:0]  d_re;
    logic        d_lock;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_rvalid;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_we;
    logic [2:0]  m_re;
    logic [31:0] m_rdata;

    logic        stall;

    modport slave (
        input  c_req, c_addr, c_wdata, c_we, c_re,
        output c_gnt, c_rdata, c_rvalid,
        input  d_req, d_addr, d_wdata, d_we, d_re, d_lock,
        output d_gnt, d_rdata, d_rvalid,
        output m_addr, m_wdata, m_we, m_re,
        input  m_rdata,
        output stall
    );

    modport master (
        output c_req, c_addr, c_wdata, c_we, c_re,
        input  c_gnt, c_rdata, c_rvalid,
        output d_req, d_addr, d_wdata, d_we, d_re, d_lock,
        input  d_gnt, d_rdata, d_rvalid,
        input  m_addr, m_wdata, m_we, m_re,
        output m_rdata,
        input  stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (C) and a
// debug/DMA requester (D), with a bounded D burst lock and registered read return.
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    dmem_arbiter_if.slave mem_io
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_C,
        RD_D
    } rd_src_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    rd_src_e     rd_src_q, rd_src_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        c_gnt;
    logic        d_gnt;
    logic        burst_ok;
    logic        arb;
    logic        prio_d;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_we;
    logic [2:0]  m_re;

    // Arbitration and next-state
    always_comb begin
        c_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        prio_d     = ptr_q;
        burst_ok   = mem_io.d_req & mem_io.d_lock & (32'(lock_cnt_q) < MAX_LOCK);
        arb        = 1'b1;

        if (state_q == LOCKED) begin
            if (burst_ok) begin
                arb        = 1'b0;
                d_gnt      = 1'b1;
                lock_cnt_d = lock_cnt_q + 8'd1;
            end else begin
                // Burst ends: arbitrate this cycle with C first so a waiting core gets its slot.
                state_d    = IDLE;
                lock_cnt_d = '0;
                ptr_d      = 1'b0;
                prio_d     = 1'b0;
            end
        end

        if (arb) begin
            if (mem_io.c_req && (!mem_io.d_req || !prio_d)) begin
                c_gnt = 1'b1;
            end else if (mem_io.d_req) begin
                d_gnt = 1'b1;
            end
            if (d_gnt && mem_io.d_lock) begin
                state_d    = LOCKED;
                lock_cnt_d = 8'd1;
            end
        end

        if (c_gnt) begin
            ptr_d = 1'b1;
        end
        if (d_gnt) begin
            ptr_d = 1'b0;
        end
    end

    // Memory-side mux; address/data hold their last value when idle
    always_comb begin
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_we    = '0;
        m_re    = '0;
        if (c_gnt) begin
            m_addr  = mem_io.c_addr;
            m_wdata = mem_io.c_wdata;
            m_we    = mem_io.c_we;
            m_re    = mem_io.c_re;
        end else if (d_gnt) begin
            m_addr  = mem_io.d_addr;
            m_wdata = mem_io.d_wdata;
            m_we    = mem_io.d_we;
            m_re    = mem_io.d_re;
        end
    end

    // Read-return capture
    always_comb begin
        addr_d    = m_addr;
        wdata_d   = m_wdata;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        rd_src_d  = RD_NONE;
        if (c_gnt && (mem_io.c_re != 3'b000)) begin
            c_rdata_d = mem_io.m_rdata;
            rd_src_d  = RD_C;
        end else if (d_gnt && (mem_io.d_re != 3'b000)) begin
            d_rdata_d = mem_io.m_rdata;
            rd_src_d  = RD_D;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            lock_cnt_q <= '0;
            rd_src_q   <= RD_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rd_src_q   <= rd_src_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_io.c_gnt    = c_gnt;
    assign mem_io.d_gnt    = d_gnt;
    assign mem_io.c_rdata  = c_rdata_q;
    assign mem_io.d_rdata  = d_rdata_q;
    assign mem_io.c_rvalid = (rd_src_q == RD_C);
    assign mem_io.d_rvalid = (rd_src_q == RD_D);
    assign mem_io.m_addr   = m_addr;
    assign mem_io.m_wdata  = m_wdata;
    assign mem_io.m_we     = m_we;
    assign mem_io.m_re     = m_re;
    assign mem_io.stall    = mem_io.c_req & ~c_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_LOCK = 3).
module tb_dmem_arbiter;

    logic clk_i;
    logic rst_ni;
    int unsigned n_assert;
    int unsigned n_fail;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_LOCK(3)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .mem_io (bus.slave)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        bus.c_req = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_we = '0; bus.c_re = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = '0; bus.d_re = '0;
        bus.d_lock = 1'b0;
    endtask

    logic [3:0] cont_c;
    logic [3:0] cont_d;
    logic [5:0] burst_c;
    logic [5:0] burst_d;
    logic [5:0] burst_stall;

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        cont_c      = 4'b0101;
        cont_d      = 4'b1010;
        burst_c     = 6'b010001;
        burst_d     = 6'b101110;
        burst_stall = 6'b001110;
        idle_all();
        bus.m_rdata = '0;
        rst_ni = 1'b1;

        // Reset with both ports requesting loads
        #1;
        bus.c_req = 1'b1; bus.c_addr = 32'h100; bus.c_re = 3'b001;
        bus.d_req = 1'b1; bus.d_addr = 32'h200; bus.d_re = 3'b010; bus.d_we = 2'b11;
        bus.m_rdata = 32'h55AA55AA;
        rst_ni = 1'b0;
        #1;
        chk("rst_c_rdata", bus.c_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_c_rvalid", 32'(bus.c_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        #10;
        rst_ni = 1'b1;
        #1;
        chk("post_rst_c_gnt", 32'(bus.c_gnt), 32'h1);
        chk("post_rst_d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("post_rst_m_addr", bus.m_addr, 32'h100);
        chk("post_rst_m_re", 32'(bus.m_re), 32'h1);
        next_cycle();
        idle_all();
        chk("post_rst_c_rvalid", 32'(bus.c_rvalid), 32'h1);
        chk("post_rst_c_rdata", bus.c_rdata, 32'h55AA55AA);
        next_cycle();
        chk("rvalid_pulse_end", 32'(bus.c_rvalid), 32'h0);

        // Single core load
        bus.c_req = 1'b1; bus.c_addr = 32'h8; bus.c_re = 3'b010;
        bus.m_rdata = 32'hDEADBEEF;
        #1;
        chk("load_c_gnt", 32'(bus.c_gnt), 32'h1);
        chk("load_stall", 32'(bus.stall), 32'h0);
        chk("load_m_addr", bus.m_addr, 32'h8);
        chk("load_m_re", 32'(bus.m_re), 32'h2);
        next_cycle();
        idle_all();
        chk("load_c_rvalid", 32'(bus.c_rvalid), 32'h1);
        chk("load_c_rdata", bus.c_rdata, 32'hDEADBEEF);
        chk("load_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        next_cycle();

        // Port D byte store, then an idle cycle
        bus.d_req = 1'b1; bus.d_we = 2'b01; bus.d_addr = 32'h4; bus.d_wdata = 32'hAB;
        #1;
        chk("st_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("st_c_gnt", 32'(bus.c_gnt), 32'h0);
        chk("st_m_we", 32'(bus.m_we), 32'h1);
        chk("st_m_addr", bus.m_addr, 32'h4);
        chk("st_m_wdata", bus.m_wdata, 32'hAB);
        chk("st_m_re", 32'(bus.m_re), 32'h0);
        next_cycle();
        idle_all();
        #1;
        chk("idle_m_we", 32'(bus.m_we), 32'h0);
        chk("idle_m_re", 32'(bus.m_re), 32'h0);
        chk("idle_m_addr_hold", bus.m_addr, 32'h4);
        chk("idle_m_wdata_hold", bus.m_wdata, 32'hAB);
        chk("idle_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("idle_c_rvalid", 32'(bus.c_rvalid), 32'h0);
        next_cycle();

        // Unlocked contention: C,D,C,D
        bus.c_req = 1'b1; bus.c_we = 2'b11; bus.c_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont%0d_c_gnt", i), 32'(bus.c_gnt), 32'(cont_c[i]));
            chk($sformatf("cont%0d_d_gnt", i), 32'(bus.d_gnt), 32'(cont_d[i]));
            chk($sformatf("cont%0d_stall", i), 32'(bus.stall), 32'(cont_d[i]));
            chk($sformatf("cont%0d_m_addr", i), bus.m_addr, cont_c[i] ? 32'h10 : 32'h20);
            next_cycle();
        end
        idle_all();
        next_cycle();

        // Burst lock with MAX_LOCK=3: C,D,D,D,C,D
        bus.c_req = 1'b1; bus.c_addr = 32'h30;
        bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.c_req = 1'b0;
            #1;
            chk($sformatf("burst%0d_c_gnt", i), 32'(bus.c_gnt), 32'(burst_c[i]));
            chk($sformatf("burst%0d_d_gnt", i), 32'(bus.d_gnt), 32'(burst_d[i]));
            chk($sformatf("burst%0d_stall", i), 32'(bus.stall), 32'(burst_stall[i]));
            next_cycle();
        end

        // Reset during the 2nd locked grant of the renewed burst
        bus.d_re = 3'b010; bus.m_rdata = 32'hCAFEF00D;
        #1;
        chk("rb_d_gnt", 32'(bus.d_gnt), 32'h1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rb_rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        next_cycle();
        chk("rb_after_edge_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("rb_after_edge_d_rdata", bus.d_rdata, 32'h0);
        #1;
        rst_ni = 1'b1;
        bus.c_req = 1'b1; bus.d_lock = 1'b0;
        #1;
        chk("rb_release_c_gnt", 32'(bus.c_gnt), 32'h1);
        chk("rb_release_d_gnt", 32'(bus.d_gnt), 32'h0);
        next_cycle();
        idle_all();
        chk("rb_release_d_rvalid", 32'(bus.d_rvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
